// File: rtl/async_reset_shift_reg.sv
// async_reset_shift_reg
//   WIDTH-bit, DEPTH-stage enabled shift register. Every stage resets
//   asynchronously to INIT. A synchronous clear also reloads INIT. A saturating
//   counter tracks the enabled shifts since the last reset or clear, so
//   "primed" marks the point where every stage holds post-reset data.
//
// Ports
//   clk     in   rising-edge clock
//   rst     in   asynchronous, active-high reset (release must be synchronised by caller)
//   en      in   shift enable
//   clr     in   synchronous clear, wins over en
//   d       in   [WIDTH-1:0] data into stage 0
//   q       out  [WIDTH-1:0] data from stage DEPTH-1
//   primed  out  high once DEPTH enabled shifts have happened since rst/clr
//   count   out  [$clog2(DEPTH+1)-1:0] enabled shifts since rst/clr, saturating at DEPTH

module async_reset_shift_reg #(
  parameter int               WIDTH = 1,
  parameter int               DEPTH = 3,
  parameter logic [WIDTH-1:0] INIT  = '0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic                         clr,
  input  logic [WIDTH-1:0]             d,
  output logic [WIDTH-1:0]             q,
  output logic                         primed,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int             CW      = $clog2(DEPTH + 1);
  localparam logic [CW-1:0]  CNT_MAX = CW'(DEPTH);

  logic [WIDTH-1:0] s [DEPTH];
  logic [CW-1:0]    cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) s[i] <= INIT;
      cnt <= '0;
    end else if (clr) begin
      for (int i = 0; i < DEPTH; i++) s[i] <= INIT;
      cnt <= '0;
    end else if (en) begin
      s[0] <= d;
      for (int i = 1; i < DEPTH; i++) s[i] <= s[i-1];
      // Saturate rather than wrap so primed stays high until rst/clr.
      if (cnt != CNT_MAX) cnt <= cnt + CW'(1);
    end
  end

  // While rst is high the outputs are forced to their reset values directly,
  // independent of how the flops resolve during the reset pulse.
  assign q      = rst ? INIT : s[DEPTH-1];
  assign primed = !rst && (cnt == CNT_MAX);
  assign count  = rst ? '0 : cnt;

endmodule

// File: tb/tb_async_reset_shift_reg.sv
module tb_async_reset_shift_reg;

  localparam logic [7:0] INIT8 = 8'hA5;

  logic clk = 1'b0;
  logic clk_run = 1'b0;
  always #5 clk = clk_run ? ~clk : clk;

  // DUT A: WIDTH=8, DEPTH=3, INIT=A5
  logic       rst = 1'b0, en = 1'b0, clr = 1'b0;
  logic [7:0] d = '0;
  logic [7:0] q;
  logic       primed;
  logic [1:0] count;

  async_reset_shift_reg #(.WIDTH(8), .DEPTH(3), .INIT(INIT8)) dut_a (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .d(d),
    .q(q), .primed(primed), .count(count)
  );

  // DUT B: WIDTH=1, DEPTH=1, INIT=1
  logic rst1 = 1'b0, en1 = 1'b0, clr1 = 1'b0, d1 = 1'b0;
  logic q1, primed1;
  logic [0:0] count1;

  async_reset_shift_reg #(.WIDTH(1), .DEPTH(1), .INIT(1'b1)) dut_b (
    .clk(clk), .rst(rst1), .en(en1), .clr(clr1), .d(d1),
    .q(q1), .primed(primed1), .count(count1)
  );

  int passed = 0;
  int total  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  typedef struct {
    logic       en;
    logic       clr;
    logic [7:0] d;
    logic [7:0] q;
    logic       primed;
    logic [1:0] count;
  } vec_t;

  vec_t vecs[14];

  // Reference model: newest entry at index 0, output is the oldest entry.
  logic [7:0] mq[$];
  int         mcnt;

  task automatic mreset();
    mq = '{INIT8, INIT8, INIT8};
    mcnt = 0;
  endtask

  task automatic mstep(input logic men, input logic mclr, input logic [7:0] md);
    if (mclr) mreset();
    else if (men) begin
      mq.push_front(md);
      void'(mq.pop_back());
      if (mcnt < 3) mcnt++;
    end
  endtask

  task automatic check_a(input string tag, input logic [7:0] eq, input logic ep, input logic [1:0] ec);
    chk({tag, ".q"}, 32'(q), 32'(eq));
    chk({tag, ".primed"}, 32'(primed), 32'(ep));
    chk({tag, ".count"}, 32'(count), 32'(ec));
  endtask

  initial begin
    // Test 1: async reset with the clock stopped.
    #1 rst = 1'b1; rst1 = 1'b1;
    #2;
    check_a("t1_rst", 8'hA5, 1'b0, 2'd0);
    chk("t6_rst.q1", 32'(q1), 32'd1);
    chk("t6_rst.primed1", 32'(primed1), 32'd0);
    clk_run = 1'b1;

    // Tests 2-4 as a vector table.
    vecs[0]  = '{1'b1, 1'b0, 8'h01, 8'hA5, 1'b0, 2'd1};
    vecs[1]  = '{1'b1, 1'b0, 8'h02, 8'hA5, 1'b0, 2'd2};
    vecs[2]  = '{1'b1, 1'b0, 8'h03, 8'h01, 1'b1, 2'd3};
    vecs[3]  = '{1'b1, 1'b0, 8'h04, 8'h02, 1'b1, 2'd3};
    vecs[4]  = '{1'b1, 1'b0, 8'h10, 8'h03, 1'b1, 2'd3};
    vecs[5]  = '{1'b0, 1'b0, 8'h11, 8'h03, 1'b1, 2'd3};
    vecs[6]  = '{1'b0, 1'b0, 8'h12, 8'h03, 1'b1, 2'd3};
    vecs[7]  = '{1'b1, 1'b0, 8'h13, 8'h04, 1'b1, 2'd3};
    vecs[8]  = '{1'b1, 1'b1, 8'h77, 8'hA5, 1'b0, 2'd0};
    vecs[9]  = '{1'b1, 1'b0, 8'h55, 8'hA5, 1'b0, 2'd1};
    vecs[10] = '{1'b1, 1'b0, 8'h66, 8'hA5, 1'b0, 2'd2};
    vecs[11] = '{1'b0, 1'b1, 8'h99, 8'hA5, 1'b0, 2'd0};
    vecs[12] = '{1'b1, 1'b0, 8'h31, 8'hA5, 1'b0, 2'd1};
    vecs[13] = '{1'b1, 1'b0, 8'h32, 8'hA5, 1'b0, 2'd2};

    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 14; i++) begin
      en = vecs[i].en; clr = vecs[i].clr; d = vecs[i].d;
      @(posedge clk); #1;
      check_a($sformatf("vec%0d", i), vecs[i].q, vecs[i].primed, vecs[i].count);
      @(negedge clk);
    end

    // Fill the pipe, then pulse rst between clock edges (test 5).
    en = 1'b1; clr = 1'b0; d = 8'h33;
    @(posedge clk); #1;
    check_a("t5_fill", 8'h31, 1'b1, 2'd3);
    @(negedge clk);
    en = 1'b0;
    #1 rst = 1'b1;
    #1 check_a("t5_rst_pulse", 8'hA5, 1'b0, 2'd0);
    #1 rst = 1'b0;
    #1 check_a("t5_after_release", 8'hA5, 1'b0, 2'd0);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      en = 1'b1; d = 8'h21 + 8'(i);
      @(posedge clk); #1;
      check_a($sformatf("t5_refill%0d", i), (i == 2) ? 8'h21 : 8'hA5,
              (i == 2), 2'(i + 1));
      @(negedge clk);
    end
    en = 1'b0;

    // Test 6: DEPTH=1 instance.
    rst1 = 1'b0; en1 = 1'b1; d1 = 1'b0;
    @(posedge clk); #1;
    chk("t6_shift.q1", 32'(q1), 32'd0);
    chk("t6_shift.primed1", 32'(primed1), 32'd1);
    chk("t6_shift.count1", 32'(count1), 32'd1);
    @(negedge clk);
    en1 = 1'b0; d1 = 1'b1;
    @(posedge clk); #1;
    chk("t6_hold.q1", 32'(q1), 32'd0);
    chk("t6_hold.count1", 32'(count1), 32'd1);
    @(negedge clk);
    en1 = 1'b1; d1 = 1'b1;
    @(posedge clk); #1;
    chk("t6_shift2.q1", 32'(q1), 32'd1);
    chk("t6_shift2.primed1", 32'(primed1), 32'd1);
    @(negedge clk);
    clr1 = 1'b1; en1 = 1'b1; d1 = 1'b0;
    @(posedge clk); #1;
    chk("t6_clr.q1", 32'(q1), 32'd1);
    chk("t6_clr.primed1", 32'(primed1), 32'd0);
    @(negedge clk);
    clr1 = 1'b0; en1 = 1'b0;

    // Randomized run against the queue model.
    rst = 1'b1; #1; mreset(); rst = 1'b0;
    for (int c = 0; c < 400; c++) begin
      int rsel;
      @(negedge clk);
      rsel = $urandom_range(0, 24);
      en  = 1'($urandom_range(0, 2) != 0);
      clr = ($urandom_range(0, 11) == 0);
      d   = 8'($urandom);
      if (rsel == 0) begin
        rst = 1'b1; #1; mreset();
        check_a("rnd_rst_pulse", 8'hA5, 1'b0, 2'd0);
        rst = 1'b0;
      end else if (rsel == 1) begin
        rst = 1'b1; #1; mreset();
      end else begin
        rst = 1'b0;
      end
      @(posedge clk);
      if (!rst) mstep(en, clr, d);
      #1;
      check_a($sformatf("rnd%0d", c), mq[2], (mcnt == 3), 2'(mcnt));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1);
  end

endmodule
